// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: one write port with byte-lane enables and one read port.
// Optional output register, optional write-first forwarding, and a read-valid pipeline.
module sdp_ram_be #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int BYTE_W  = 8,
  parameter int OUT_REG = 1,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/BYTE_W-1:0]   wr_be,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit FWD   = (BYPASS != 0);

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_cfg
    $error("sdp_ram_be: DATA_W (%0d) must be a multiple of BYTE_W (%0d)", DATA_W, BYTE_W);
  end

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] old_word_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              hit_s;
  logic [DATA_W-1:0] s1_data_r;
  logic              s1_valid_r;

  // Array update: only enabled lanes change; writes are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_r[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word selection; a same-address write forwards only its enabled lanes.
  always_comb begin
    old_word_s = mem_r[rd_addr];
    rd_word_s  = '0;
    hit_s      = FWD && wr_en && (wr_addr == rd_addr);
    for (int i = 0; i < NB; i++) begin
      if (hit_s && wr_be[i]) begin
        rd_word_s[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end else begin
        rd_word_s[i*BYTE_W +: BYTE_W] = old_word_s[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // First read stage: capturing here isolates the result from any later write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_r  <= '0;
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= rd_en;
      if (rd_en) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] s2_data_r;
    logic              s2_valid_r;

    // Second stage only loads on a valid result so rd_data holds between reads.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_data_r  <= '0;
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_data_r <= s1_data_r;
        end
      end
    end

    assign rd_data  = s2_data_r;
    assign rd_valid = s2_valid_r;
  end else begin : g_no_out_reg
    assign rd_data  = s1_data_r;
    assign rd_valid = s1_valid_r;
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// Scoreboard bench for sdp_ram_be: a driver predicts each read from an array model,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_sdp_ram_be #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int BYTE_W  = 8,
  parameter int OUT_REG = 1,
  parameter int BYPASS  = 1
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  sdp_ram_be #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W), .OUT_REG(OUT_REG), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic [DATA_W-1:0] model [DEPTH];
  exp_t              q [$];
  logic [DATA_W-1:0] hold_exp;
  int                edge_cnt;
  int                n_checks;
  int                n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] lane_rep(input int a);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*BYTE_W +: BYTE_W] = BYTE_W'(a);
    return r;
  endfunction

  // One clock of stimulus; the prediction for a read is pushed as it is issued.
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                     input logic [NB-1:0] be, input logic re, input logic [ADDR_W-1:0] ra);
    exp_t e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (re) begin
      e.data = model[ra];
      if (BYPASS != 0 && we && wa == ra) e.data = merge(model[ra], wd, be);
      e.due = edge_cnt + 1 + OUT_REG;
      q.push_back(e);
    end
    if (we) model[wa] = merge(model[wa], wd, be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Monitor: pops the scoreboard on every rd_valid and checks hold/latency otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("reset_rd_data", 64'(rd_data), 64'd0);
    end else if (rd_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", {63'd0, rd_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("rd_latency", 64'(edge_cnt), 64'(e.due));
        chk("rd_data", 64'(rd_data), 64'(e.data));
        hold_exp = e.data;
      end
    end else begin
      chk("hold_data", 64'(rd_data), 64'(hold_exp));
      if (q.size() > 0 && q[0].due <= edge_cnt) begin
        void'(q.pop_front());
        chk("missing_valid", {63'd0, rd_valid}, 64'd1);
      end
    end
  end

  // Async reset between edges with reads in flight and a write attempt held during reset.
  task automatic mid_reset();
    logic [DATA_W-1:0] wd;
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(1));
    @(posedge clk);
    #2;
    wd = ~model[5];
    reset = 1'b1;
    rd_en = 1'b1; rd_addr = ADDR_W'(2);
    wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = wd; wr_be = '1;
    #1;
    chk("async_reset_valid", {63'd0, rd_valid}, 64'd0);
    chk("async_reset_data", 64'(rd_data), 64'd0);
    q.delete();
    hold_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] wa, ra;
    logic              we, re;
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    hold_exp = '0; edge_cnt = 0; n_checks = 0; n_errors = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic write then read
    cyc(1'b1, ADDR_W'(3), DATA_W'(32'hDEADBEEF), '1, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(3));
    idle(3);

    // Byte enables, then an all-lanes-off write
    cyc(1'b1, ADDR_W'(7), DATA_W'(32'h11223344), '1, 1'b0, '0);
    cyc(1'b1, ADDR_W'(7), DATA_W'(32'hAABBCCDD), NB'(4'b0101), 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(7));
    cyc(1'b1, ADDR_W'(7), DATA_W'(32'h55667788), '0, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(7));
    idle(3);

    // Same-address read-during-write, then a plain re-read
    cyc(1'b1, ADDR_W'(9), '0, '1, 1'b0, '0);
    cyc(1'b1, ADDR_W'(9), '1, NB'(4'b0011), 1'b1, ADDR_W'(9));
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(9));
    idle(3);

    // Fill every address, then stream back-to-back reads through the pipeline
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, ADDR_W'(a), lane_rep(a), '1, 1'b0, '0);
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a));
    idle(4);

    // Random traffic concentrated on a few addresses to provoke collisions
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      ra = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      cyc(we, wa, DATA_W'({$urandom, $urandom}), NB'($urandom), re, ra);
    end
    idle(3);

    // Reset with reads in flight; afterwards memory must be intact
    mid_reset();
    idle(3);
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(1));
    cyc(1'b0, '0, '0, '0, 1'b1, ADDR_W'(5));
    idle(OUT_REG + 4);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdp_ram_be.md
Name: sdp_ram_be

Overview:
- Parametrised single-clock simple dual-port RAM: one write port with byte enables, one read port.
- Generalises the fixed 32x32 register-file RAM used by the processor: configurable width, depth and byte size, selectable 1- or 2-cycle read latency, selectable read-during-write forwarding, and a read-valid pipeline.
- Used for the CPU register file, scratch buffers and small data memories.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 5: address width; depth = 2**ADDR_W words.
- BYTE_W, 8: bits per byte lane; lanes NB = DATA_W/BYTE_W.
- OUT_REG, 1: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- BYPASS, 1: 1 = same-address read-during-write returns new data (write-first); 0 = returns old data (read-first).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NB  byte-lane write enables; bit i covers wr_data[i*BYTE_W +: BYTE_W].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; held between reads.
- rd_valid  out  1  one-cycle pulse when rd_data carries a new result.

Behaviour:
- Reset (async assert, sync release):
  - rd_data = 0, rd_valid = 0, all internal read-pipeline stages and valid bits = 0.
  - Memory array is not cleared; contents are undefined until written.
  - Writes presented while reset is high are ignored.
- Write:
  - At a rising edge with wr_en=1, every lane i with wr_be[i]=1 is updated; lanes with wr_be[i]=0 keep their value.
  - wr_en=1 with wr_be=0 is a no-op.
- Read, OUT_REG=0:
  - rd_en=1 at edge N: rd_data = mem[rd_addr] after edge N, and rd_valid=1 for the cycle following edge N.
- Read, OUT_REG=1:
  - Stage 1 captures the word at edge N; stage 2 drives rd_data and rd_valid after edge N+1.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- rd_en=0: rd_data holds its last value, rd_valid=0 the following cycle. There is no other stall or back-pressure.
- Read-during-write, same address, same edge:
  - BYPASS=1: the result is a per-lane merge: wr_data lanes where wr_be=1, old memory lanes elsewhere.
  - BYPASS=0: the result is the old memory word.
  - Different addresses: no interaction.
- A write after the read's issue edge never alters that read's result, including one landing between stage 1 and stage 2.
- Reset mid-operation: in-flight reads are dropped, and no rd_valid pulse is produced for reads issued before reset.
- Address wrap: all addresses 0..2**ADDR_W-1 are valid; there is no out-of-range case.
- Illegal configuration: an elaboration-time check fails if DATA_W % BYTE_W != 0.

Test Plan:
- Basic write/read (defaults, OUT_REG=1): write 0xDEADBEEF to addr 3 with be=4'hF, then read addr 3 -> rd_data=0xDEADBEEF with rd_valid pulsing exactly 2 cycles after rd_en; with OUT_REG=0, after 1 cycle.
- Byte enables: write 0x11223344 to addr 7 (be=F), then 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD; a write with be=0 leaves 0x11BB33DD unchanged.
- Read-during-write: addr 9 holds 0x00000000; write 0xFFFFFFFF with be=4'b0011 and read addr 9 on the same edge -> BYPASS=1 returns 0x0000FFFF, BYPASS=0 returns 0x00000000; the next read returns 0x0000FFFF in both modes.
- Pipelining:
  - Fill addrs 0..31 with value addr*0x01010101.
  - Issue rd_en on 32 consecutive cycles for addrs 0..31 -> 32 consecutive rd_valid pulses with matching data in order; addr 31 returns 0x1F1F1F1F (wrap boundary).
  - Then deassert rd_en -> rd_data holds 0x1F1F1F1F and rd_valid=0.
- Reset mid-operation:
  - Issue reads to addrs 1 and 2, then assert reset asynchronously (between edges) before their results appear -> rd_data=0 and rd_valid=0 immediately, with no later valid pulse.
  - A write attempted during reset does not change memory.
  - After release, reading addr 1 returns its pre-reset contents.
- Parameter sweep: DATA_W=16, ADDR_W=4, BYTE_W=8 and DATA_W=36, BYTE_W=9 pass the byte-enable and read-during-write scenarios against a reference model.
